// File: rtl/flag_branch_unit.sv
// Flag register and branch resolver fed by the saturating ALU.
// Conditions see same-cycle forwarded flags on a per-flag basis.
module flag_branch_unit #(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              alu_valid,
  input  logic [3:0]        alu_op,
  input  logic              alu_zero,
  input  logic              alu_ovfl,
  input  logic              alu_sign,
  input  logic              br_valid,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [OFF_W-1:0]  br_offset,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n,
  output logic              br_resolved,
  output logic              br_taken,
  output logic [ADDR_W-1:0] br_target
);

  typedef enum logic [2:0] {
    CC_NEQ  = 3'b000,
    CC_EQ   = 3'b001,
    CC_GT   = 3'b010,
    CC_LT   = 3'b011,
    CC_GTE  = 3'b100,
    CC_LTE  = 3'b101,
    CC_OVFL = 3'b110,
    CC_AL   = 3'b111
  } cond_e;

  logic              z_q, v_q, n_q;
  logic              res_q, tak_q;
  logic [ADDR_W-1:0] tgt_q;

  logic              wr_all, wr_z;
  logic              eff_z, eff_v, eff_n;
  logic              cond_ok;
  logic [ADDR_W-1:0] off_sx;
  logic [ADDR_W-1:0] tgt_d;

  always_comb begin
    wr_all = 1'b0;
    wr_z   = 1'b0;
    if (alu_valid) begin
      unique case (alu_op)
        4'b0000, 4'b0001: begin
          wr_all = 1'b1;
          wr_z   = 1'b1;
        end
        4'b0010, 4'b0100,
        4'b0101, 4'b0110: wr_z = 1'b1;
        default: ;
      endcase
    end
  end

  assign eff_z = wr_z   ? alu_zero : z_q;
  assign eff_v = wr_all ? alu_ovfl : v_q;
  assign eff_n = wr_all ? alu_sign : n_q;

  always_comb begin
    cond_ok = 1'b0;
    unique case (cond_e'(br_cond))
      CC_NEQ:  cond_ok = ~eff_z;
      CC_EQ:   cond_ok = eff_z;
      CC_GT:   cond_ok = ~eff_z & ~eff_n;
      CC_LT:   cond_ok = eff_n;
      CC_GTE:  cond_ok = eff_z | ~eff_n;
      CC_LTE:  cond_ok = eff_z | eff_n;
      CC_OVFL: cond_ok = eff_v;
      CC_AL:   cond_ok = 1'b1;
    endcase
  end

  // Word offset: sign-extend, scale to bytes, carry out is dropped.
  assign off_sx = {{(ADDR_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};
  assign tgt_d  = br_pc + ADDR_W'(2) + (off_sx << 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q   <= 1'b0;
      v_q   <= 1'b0;
      n_q   <= 1'b0;
      res_q <= 1'b0;
      tak_q <= 1'b0;
      tgt_q <= '0;
    end else if (flush) begin
      res_q <= 1'b0;
    end else if (!stall) begin
      z_q   <= eff_z;
      v_q   <= eff_v;
      n_q   <= eff_n;
      res_q <= br_valid;
      if (br_valid) begin
        tak_q <= cond_ok;
        tgt_q <= tgt_d;
      end
    end
  end

  assign flag_z      = z_q;
  assign flag_v      = v_q;
  assign flag_n      = n_q;
  assign br_resolved = res_q;
  assign br_taken    = tak_q;
  assign br_target   = tgt_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed table-driven bench for flag_branch_unit.
// Each row is one clock: inputs, then expected outputs after the edge.
module tb_flag_branch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        alu_valid;
  logic [3:0]  alu_op;
  logic        alu_zero, alu_ovfl, alu_sign;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [15:0] br_pc;
  logic [8:0]  br_offset;
  logic        flag_z, flag_v, flag_n;
  logic        br_resolved, br_taken;
  logic [15:0] br_target;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flag_branch_unit #(.ADDR_W(16), .OFF_W(9)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .alu_valid(alu_valid), .alu_op(alu_op),
    .alu_zero(alu_zero), .alu_ovfl(alu_ovfl),
    .alu_sign(alu_sign), .br_valid(br_valid),
    .br_cond(br_cond), .br_pc(br_pc),
    .br_offset(br_offset), .flag_z(flag_z),
    .flag_v(flag_v), .flag_n(flag_n),
    .br_resolved(br_resolved), .br_taken(br_taken),
    .br_target(br_target)
  );

  typedef struct {
    logic        rst, stall, flush;
    logic        av;
    logic [3:0]  op;
    logic        az, ao, as;
    logic        bv;
    logic [2:0]  cc;
    logic [15:0] pc;
    logic [8:0]  off;
    logic        ez, ev, en;
    logic        eres, etak;
    logic [15:0] etgt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int idx,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row%0d %s got=%h want=%h",
               idx, nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    rst       = v.rst;
    stall     = v.stall;
    flush     = v.flush;
    alu_valid = v.av;
    alu_op    = v.op;
    alu_zero  = v.az;
    alu_ovfl  = v.ao;
    alu_sign  = v.as;
    br_valid  = v.bv;
    br_cond   = v.cc;
    br_pc     = v.pc;
    br_offset = v.off;
    @(posedge clk);
    #1;
    chk("flag_z", idx, 16'(flag_z), 16'(v.ez));
    chk("flag_v", idx, 16'(flag_v), 16'(v.ev));
    chk("flag_n", idx, 16'(flag_n), 16'(v.en));
    chk("resolved", idx, 16'(br_resolved), 16'(v.eres));
    chk("taken", idx, 16'(br_taken), 16'(v.etak));
    chk("target", idx, br_target, v.etgt);
  endtask

  initial begin
    vec_t h;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    alu_valid = 1'b0; alu_op = 4'h0;
    alu_zero = 1'b0; alu_ovfl = 1'b0; alu_sign = 1'b0;
    br_valid = 1'b0; br_cond = 3'd0;
    br_pc = 16'h0; br_offset = 9'h0;

    // rst st fl av op az ao as bv cc pc off | z v n res tak tgt
    vecs.push_back('{1,0,0,0,4'h0,0,0,0,0,3'd0,16'h0000,9'h000,0,0,0,0,0,16'h0000});
    vecs.push_back('{1,0,0,0,4'h0,0,0,0,0,3'd0,16'h0000,9'h000,0,0,0,0,0,16'h0000});
    vecs.push_back('{0,0,0,0,4'h0,0,0,0,0,3'd0,16'h0000,9'h000,0,0,0,0,0,16'h0000});
    vecs.push_back('{0,0,0,1,4'h0,1,0,0,0,3'd0,16'h0000,9'h000,1,0,0,0,0,16'h0000});
    vecs.push_back('{0,0,0,0,4'h0,0,0,0,1,3'd1,16'h0010,9'h003,1,0,0,1,1,16'h0018});
    vecs.push_back('{0,0,0,1,4'h0,0,1,1,0,3'd0,16'h0000,9'h000,0,1,1,0,1,16'h0018});
    vecs.push_back('{0,0,0,1,4'h2,0,0,0,0,3'd0,16'h0000,9'h000,0,1,1,0,1,16'h0018});
    vecs.push_back('{0,0,0,0,4'h0,0,0,0,1,3'd6,16'h0100,9'h1FF,0,1,1,1,1,16'h0100});
    vecs.push_back('{0,0,0,1,4'h1,0,0,0,0,3'd0,16'h0000,9'h000,0,0,0,0,1,16'h0100});
    vecs.push_back('{0,0,0,1,4'h1,0,0,1,1,3'd3,16'h0200,9'h000,0,0,1,1,1,16'h0202});
    vecs.push_back('{0,0,0,1,4'h0,0,0,0,0,3'd0,16'h0000,9'h000,0,0,0,0,1,16'h0202});
    vecs.push_back('{0,0,0,1,4'hA,0,0,1,1,3'd3,16'h0300,9'h001,0,0,0,1,0,16'h0304});
    vecs.push_back('{0,0,0,1,4'h0,0,0,1,0,3'd0,16'h0000,9'h000,0,0,1,0,0,16'h0304});
    vecs.push_back('{0,0,0,1,4'h2,0,0,0,1,3'd2,16'h0400,9'h1FE,0,0,1,1,0,16'h03FE});
    vecs.push_back('{0,0,0,1,4'h2,1,0,0,1,3'd1,16'h0010,9'h000,1,0,1,1,1,16'h0012});
    vecs.push_back('{0,0,0,1,4'h0,0,0,0,0,3'd0,16'h0000,9'h000,0,0,0,0,1,16'h0012});
    vecs.push_back('{0,0,0,0,4'h0,0,0,0,1,3'd2,16'h0020,9'h004,0,0,0,1,1,16'h002A});
    vecs.push_back('{0,1,0,1,4'h0,1,0,0,1,3'd1,16'h0050,9'h000,0,0,0,1,1,16'h002A});
    vecs.push_back('{0,1,0,1,4'h0,1,0,0,1,3'd1,16'h0050,9'h000,0,0,0,1,1,16'h002A});
    vecs.push_back('{0,1,0,1,4'h0,1,0,0,1,3'd1,16'h0050,9'h000,0,0,0,1,1,16'h002A});
    vecs.push_back('{0,0,0,0,4'h0,0,0,0,0,3'd0,16'h0000,9'h000,0,0,0,0,1,16'h002A});
    vecs.push_back('{0,0,0,0,4'h0,0,0,0,1,3'd0,16'h0070,9'h000,0,0,0,1,1,16'h0072});
    vecs.push_back('{0,1,1,1,4'h0,1,1,1,1,3'd1,16'h0060,9'h000,0,0,0,0,1,16'h0072});
    vecs.push_back('{0,0,0,0,4'h0,0,0,0,1,3'd7,16'hFFFE,9'h000,0,0,0,1,1,16'h0000});
    vecs.push_back('{0,0,0,0,4'h0,0,0,0,1,3'd4,16'h0000,9'h000,0,0,0,1,1,16'h0002});
    vecs.push_back('{0,0,0,0,4'h0,0,0,0,1,3'd5,16'h0000,9'h000,0,0,0,1,0,16'h0002});
    vecs.push_back('{0,0,0,1,4'h6,1,1,1,0,3'd0,16'h0000,9'h000,1,0,0,0,0,16'h0002});

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Capture a branch, then reset while stalled with a new branch.
    h = '{0,0,0,0,4'h0,0,0,0,1,3'd7,16'h1234,9'h000,1,0,0,1,1,16'h1236};
    step(h, 100);
    h = '{1,1,0,1,4'h0,1,1,1,1,3'd7,16'h5555,9'h005,0,0,0,0,0,16'h0000};
    step(h, 101);
    h = '{0,0,0,0,4'h0,0,0,0,0,3'd0,16'h0000,9'h000,0,0,0,0,0,16'h0000};
    step(h, 102);

    // Stalled cycle with no pending pulse keeps resolved low.
    h = '{0,1,0,0,4'h0,0,0,0,1,3'd7,16'h0040,9'h000,0,0,0,0,0,16'h0000};
    step(h, 103);
    h = '{0,0,0,0,4'h0,0,0,0,1,3'd6,16'h0040,9'h0FF,0,0,0,1,0,16'h0240};
    step(h, 104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
